dds_nco_ctrl: RTL and testbench

Parametrised multi-channel NCO controller for the DDS datapath. It owns the frequency tuning word, the phase accumulator, and per-channel phase offsets, and it sequences them through an IDLE/LOAD/RUN/SWEEP state machine. It produces NUM_CH truncated phase indices per cycle for the downstream sin/cos LUTs, and adds a linear frequency-sweep (chirp) mode plus a phase-sync input.

---
 rtl/dds_nco_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dds_nco_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_nco_ctrl.sv
// Multi-channel NCO controller: tuning word, phase accumulator, per-channel
// offsets and chirp sweep, sequenced through IDLE/LOAD/RUN/SWEEP.
module dds_nco_ctrl #(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 10,
    parameter int NUM_CH  = 2,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      load_i,
    input  logic                      mode_i,
    input  logic [PHASE_W-1:0]        freq_i,
    input  logic [PHASE_W-1:0]        step_i,
    input  logic [PHASE_W-1:0]        fmax_i,
    input  logic                      sync_i,
    input  logic                      off_we_i,
    input  logic [CH_W-1:0]           off_ch_i,
    input  logic [PHASE_W-1:0]        off_i,
    output logic [NUM_CH*OUT_W-1:0]   phase_o,
    output logic                      valid_o,
    output logic                      wrap_o,
    output logic                      sweep_done_o,
    output logic [PHASE_W-1:0]        freq_o,
    output logic [1:0]                state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_SWEEP = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [PHASE_W-1:0]   r_acc;
    logic [PHASE_W-1:0]   r_freq;
    logic [PHASE_W-1:0]   r_fstart;
    logic [PHASE_W-1:0]   r_step;
    logic [PHASE_W-1:0]   r_fmax;
    logic                 r_mode;
    logic [PHASE_W-1:0]   r_off [NUM_CH];
    logic [NUM_CH*OUT_W-1:0] r_phase;
    logic                 r_valid;
    logic                 r_wrap;
    logic                 r_done;

    logic [PHASE_W:0]     w_sum;
    logic [PHASE_W-1:0]   w_acc_new;
    logic                 w_wrap;
    logic [PHASE_W:0]     w_s;
    logic                 w_over;
    logic [NUM_CH*OUT_W-1:0] w_phase;
    logic                 w_off_ok;

    // Truncated phase index of accumulator plus offset, modulo 2^PHASE_W.
    function automatic logic [OUT_W-1:0] f_idx(
        input logic [PHASE_W-1:0] a,
        input logic [PHASE_W-1:0] b
    );
        logic [PHASE_W-1:0] s;
        s = a + b;
        return s[PHASE_W-1 -: OUT_W];
    endfunction

    always_comb begin
        w_next = r_mode ? S_SWEEP : S_RUN;
        if (!en_i) begin
            w_next = S_IDLE;
        end else if (load_i) begin
            w_next = S_LOAD;
        end
    end

    always_comb begin
        w_sum     = {1'b0, r_acc} + {1'b0, r_freq};
        w_acc_new = sync_i ? '0 : w_sum[PHASE_W-1:0];
        w_wrap    = ~sync_i & w_sum[PHASE_W];
        w_s       = {1'b0, r_freq} + {1'b0, r_step};
        w_over    = (w_s > {1'b0, r_fmax});
        w_off_ok  = (int'(off_ch_i) < NUM_CH);
        w_phase   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_phase[k*OUT_W +: OUT_W] = f_idx(w_acc_new, r_off[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_freq   <= '0;
            r_fstart <= '0;
            r_step   <= '0;
            r_fmax   <= '0;
            r_mode   <= 1'b0;
            r_phase  <= '0;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
            r_done   <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_off[k] <= '0;
            end
        end else begin
            r_state <= w_next;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
            if (off_we_i && w_off_ok) begin
                r_off[off_ch_i] <= off_i;
            end
            unique case (w_next)
                S_IDLE: begin
                    r_acc    <= '0;
                    r_freq   <= '0;
                    r_fstart <= '0;
                    r_step   <= '0;
                    r_fmax   <= '0;
                    r_mode   <= 1'b0;
                    r_phase  <= '0;
                    r_valid  <= 1'b0;
                end
                S_LOAD: begin
                    r_freq   <= freq_i;
                    r_fstart <= freq_i;
                    r_step   <= step_i;
                    r_fmax   <= fmax_i;
                    r_mode   <= mode_i;
                    r_valid  <= 1'b0;
                end
                S_RUN: begin
                    r_acc   <= w_acc_new;
                    r_wrap  <= w_wrap;
                    r_phase <= w_phase;
                    r_valid <= 1'b1;
                end
                S_SWEEP: begin
                    r_acc   <= w_acc_new;
                    r_wrap  <= w_wrap;
                    r_phase <= w_phase;
                    r_valid <= 1'b1;
                    if (w_over) begin
                        r_freq <= r_fstart;
                        r_done <= 1'b1;
                    end else begin
                        r_freq <= w_s[PHASE_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign phase_o      = r_phase;
    assign valid_o      = r_valid;
    assign wrap_o       = r_wrap;
    assign sweep_done_o = r_done;
    assign freq_o       = r_freq;
    assign state_o      = r_state;

endmodule

// File: tb/tb_dds_nco_ctrl.sv
// Directed table-driven bench for dds_nco_ctrl plus hand-written
// sequences for wrap, sweep, sync, reset and enable corner cases.
module tb_dds_nco_ctrl;

    localparam int PW = 24;
    localparam int OW = 10;
    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en_i = 1'b0;
    logic          load_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [PW-1:0] freq_i = '0;
    logic [PW-1:0] step_i = '0;
    logic [PW-1:0] fmax_i = '0;
    logic          sync_i = 1'b0;
    logic          off_we_i = 1'b0;
    logic          off_ch_i = 1'b0;
    logic [PW-1:0] off_i = '0;
    logic [NC*OW-1:0] phase_o;
    logic          valid_o;
    logic          wrap_o;
    logic          sweep_done_o;
    logic [PW-1:0] freq_o;
    logic [1:0]    state_o;

    int errors = 0;
    int checks = 0;

    dds_nco_ctrl #(.PHASE_W(PW), .OUT_W(OW), .NUM_CH(NC)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .load_i(load_i),
        .mode_i(mode_i), .freq_i(freq_i), .step_i(step_i),
        .fmax_i(fmax_i), .sync_i(sync_i), .off_we_i(off_we_i),
        .off_ch_i(off_ch_i), .off_i(off_i), .phase_o(phase_o),
        .valid_o(valid_o), .wrap_o(wrap_o),
        .sweep_done_o(sweep_done_o), .freq_o(freq_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en, load, sync, owe, och;
        logic [PW-1:0] freq, off;
        logic [1:0]    est;
        logic          ev, ew;
        logic [PW-1:0] efreq;
        logic [OW-1:0] ep0, ep1;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic ld,
                         input logic md, input logic [PW-1:0] f,
                         input logic [PW-1:0] st,
                         input logic [PW-1:0] fm);
        en_i = en; load_i = ld; mode_i = md;
        freq_i = f; step_i = st; fmax_i = fm;
    endtask

    function automatic vec_t mk(
        input logic en, input logic ld, input logic sy,
        input logic owe, input logic och, input logic [PW-1:0] f,
        input logic [PW-1:0] off, input logic [1:0] est,
        input logic ev, input logic ew, input logic [PW-1:0] ef,
        input logic [OW-1:0] p0, input logic [OW-1:0] p1);
        vec_t v;
        v.en = en; v.load = ld; v.sync = sy; v.owe = owe;
        v.och = och; v.freq = f; v.off = off; v.est = est;
        v.ev = ev; v.ew = ew; v.efreq = ef; v.ep0 = p0; v.ep1 = p1;
        return v;
    endfunction

    logic [PW-1:0] sw_f [8];
    logic          sw_d [8];

    initial begin
        tbl[0]  = mk(1,1,0,1,1,24'h100000,24'h400000,1,0,0,24'h100000,0,0);
        tbl[1]  = mk(1,0,0,0,0,24'h0,24'h0,2,1,0,24'h100000,64,320);
        tbl[2]  = mk(1,0,0,0,0,24'h0,24'h0,2,1,0,24'h100000,128,384);
        tbl[3]  = mk(1,0,0,0,0,24'h0,24'h0,2,1,0,24'h100000,192,448);
        tbl[4]  = mk(1,0,1,0,0,24'h0,24'h0,2,1,0,24'h100000,0,256);
        tbl[5]  = mk(1,0,0,0,0,24'h0,24'h0,2,1,0,24'h100000,64,320);
        tbl[6]  = mk(1,0,0,1,0,24'h0,24'h800000,2,1,0,24'h100000,128,384);
        tbl[7]  = mk(1,0,0,0,0,24'h0,24'h0,2,1,0,24'h100000,704,448);
        tbl[8]  = mk(1,1,0,0,0,24'h200000,24'h0,1,0,0,24'h200000,704,448);
        tbl[9]  = mk(1,0,0,0,0,24'h0,24'h0,2,1,0,24'h200000,832,576);
        tbl[10] = mk(0,0,1,0,0,24'h0,24'h0,0,0,0,24'h0,0,0);
        tbl[11] = mk(1,0,1,0,0,24'h0,24'h0,2,1,0,24'h0,512,256);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_phase", 32'(phase_o), 0);
        chk("rst_freq", 32'(freq_o), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            en_i = tbl[i].en; load_i = tbl[i].load; mode_i = 1'b0;
            freq_i = tbl[i].freq; sync_i = tbl[i].sync;
            off_we_i = tbl[i].owe; off_ch_i = tbl[i].och;
            off_i = tbl[i].off;
            tick();
            chk($sformatf("v%0d_state", i), 32'(state_o), 32'(tbl[i].est));
            chk($sformatf("v%0d_valid", i), 32'(valid_o), 32'(tbl[i].ev));
            chk($sformatf("v%0d_wrap", i), 32'(wrap_o), 32'(tbl[i].ew));
            chk($sformatf("v%0d_freq", i), 32'(freq_o), 32'(tbl[i].efreq));
            chk($sformatf("v%0d_ph0", i), 32'(phase_o[OW-1:0]),
                32'(tbl[i].ep0));
            chk($sformatf("v%0d_ph1", i), 32'(phase_o[2*OW-1:OW]),
                32'(tbl[i].ep1));
        end
        sync_i = 1'b0; off_we_i = 1'b0;

        // Sweep: 0x10 start, 0x10 step, 0x40 limit.
        sw_f[0] = 24'h20; sw_f[1] = 24'h30; sw_f[2] = 24'h40;
        sw_f[3] = 24'h10; sw_f[4] = 24'h20; sw_f[5] = 24'h30;
        sw_f[6] = 24'h40; sw_f[7] = 24'h10;
        for (int i = 0; i < 8; i++) sw_d[i] = (i == 3) || (i == 7);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 24'h10, 24'h10, 24'h40);
        tick();
        chk("sw_load_freq", 32'(freq_o), 32'h10);
        load_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sync_i = (i == 7);
            tick();
            chk($sformatf("sw%0d_state", i), 32'(state_o), 3);
            chk($sformatf("sw%0d_freq", i), 32'(freq_o), 32'(sw_f[i]));
            chk($sformatf("sw%0d_done", i), 32'(sweep_done_o),
                32'(sw_d[i]));
            if (i == 3) chk("sw3_acc", 32'(dut.r_acc), 32'hA0);
            if (i == 7) chk("sw7_sync_acc", 32'(dut.r_acc), 0);
        end
        sync_i = 1'b0;

        // Enable dropped mid-sweep, then resume without reload.
        en_i = 1'b0;
        tick();
        chk("en0_freq", 32'(freq_o), 0);
        chk("en0_valid", 32'(valid_o), 0);
        chk("en0_state", 32'(state_o), 0);
        en_i = 1'b1;
        tick();
        chk("resume_state", 32'(state_o), 2);
        chk("resume_valid", 32'(valid_o), 1);
        chk("resume_ph0", 32'(phase_o[OW-1:0]), 512);
        chk("resume_ph1", 32'(phase_o[2*OW-1:OW]), 256);

        // fstart above fmax: restart every cycle.
        drive(1, 1, 1, 24'h50, 24'h1, 24'h40);
        tick();
        load_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hi%0d_done", i), 32'(sweep_done_o), 1);
            chk($sformatf("hi%0d_freq", i), 32'(freq_o), 32'h50);
        end

        // Sum overflowing PHASE_W bits counts as above the limit.
        drive(1, 1, 1, 24'hFFFFF0, 24'h20, 24'hFFFFFF);
        tick();
        load_i = 1'b0;
        tick();
        chk("ovf_done", 32'(sweep_done_o), 1);
        chk("ovf_freq", 32'(freq_o), 32'hFFFFF0);

        // Zero step at the limit never restarts.
        drive(1, 1, 1, 24'h30, 24'h0, 24'h30);
        tick();
        load_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("st0_%0d_done", i), 32'(sweep_done_o), 0);
            chk($sformatf("st0_%0d_freq", i), 32'(freq_o), 32'h30);
        end

        // Carry-out after 16 steps of 0x100000, single-cycle pulse.
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 24'h100000, 0, 0);
        tick();
        load_i = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk($sformatf("wr%0d", i), 32'(wrap_o), 32'(i == 16));
            if (i == 16) chk("wr16_acc", 32'(dut.r_acc), 0);
        end

        // Asynchronous reset between edges.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_state", 32'(state_o), 0);
        chk("arst_valid", 32'(valid_o), 0);
        chk("arst_phase", 32'(phase_o), 0);
        chk("arst_freq", 32'(freq_o), 0);
        chk("arst_off0", 32'(dut.r_off[0]), 0);
        chk("arst_off1", 32'(dut.r_off[1]), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_state", 32'(state_o), 2);
        chk("post_phase", 32'(phase_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
